// File: rtl/shift2mat_pkg.sv
// Shared types and constants for the shift2mat serial-to-word receiver.
// SHIFT2MAT_PARITY_EN adds the PARITY state (8E1 frames).
package shift2mat_pkg;
    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SHIFT2MAT_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;
endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
import shift2mat_pkg::*;

module rx_sync #(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_d};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) sync_q <= '1;
        else       sync_q <= sync_d;
    end

    assign o_q = sync_q[STAGES-1];
endmodule

// File: rtl/shift2mat.sv
// UART receiver that assembles NUM_BYTES accepted bytes into one word (byte 0 in [7:0]).
// Define SHIFT2MAT_PARITY_EN for an even-parity bit between data and stop.
import shift2mat_pkg::*;

module shift2mat #(
    parameter int CLKS_PER_BIT = 104,
    parameter int NUM_BYTES    = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    output logic [7:0]             o_byte,
    output logic                   o_byte_valid,
    output logic [8*NUM_BYTES-1:0] o_data,
    output logic                   o_rx_done,
    output logic                   o_frame_err
);
    localparam int          IDXW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [15:0] CNT_MID = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] CNT_END = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_BYTES - 1);

    logic rx_s;

    rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    state_t                        state_q, state_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic [2:0]                    bit_q, bit_d;
    logic [DATA_BITS-1:0]          shift_q, shift_d;
    logic [7:0]                    byte_q, byte_d;
    logic                          byte_valid_q, byte_valid_d;
    logic [NUM_BYTES-1:0][7:0]     shadow_q, shadow_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic [8*NUM_BYTES-1:0]        data_q, data_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic                          stop_ok;
`ifdef SHIFT2MAT_PARITY_EN
    logic                          par_err_q, par_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        data_d       = data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
`ifdef SHIFT2MAT_PARITY_EN
        par_err_d    = par_err_q;
        stop_ok      = rx_s && !par_err_q;
`else
        stop_ok      = rx_s;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid-start recheck rejects short glitches on the idle line
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef SHIFT2MAT_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef SHIFT2MAT_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_END) begin
                    cnt_d     = '0;
                    par_err_d = rx_s ^ (^shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                    if (stop_ok) begin
                        byte_d           = shift_q;
                        byte_valid_d     = 1'b1;
                        shadow_d[idx_q]  = shift_q;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            data_d = shadow_d;
                            done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            shadow_q     <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef SHIFT2MAT_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef SHIFT2MAT_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_data       = data_q;
    assign o_rx_done    = done_q;
    assign o_frame_err  = err_q;
endmodule

// File: tb/tb_shift2mat.sv
// Scoreboard bench for shift2mat: directed frames push expectations, a negedge monitor checks pulses.
import shift2mat_pkg::*;

module tb_shift2mat;
    localparam int CPB = 16;
    localparam int NB  = 4;
`ifdef SHIFT2MAT_PARITY_EN
    localparam int LAT_EXTRA = CPB;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [7:0]    o_byte;
    logic          o_byte_valid;
    logic [8*NB-1:0] o_data;
    logic          o_rx_done;
    logic          o_frame_err;

    shift2mat #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_frame_err  (o_frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_byte_q[$];
    logic [31:0] exp_word_q[$];
    int          exp_err = 0;
    int          tests = 0;
    int          fails = 0;
    int          start_cyc = 0;
    int          last_valid_cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match a pending expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (o_byte_valid) begin
                last_valid_cyc = cyc;
                if (exp_byte_q.size() == 0) check("unexpected_byte_valid", {24'd0, o_byte}, 32'hFFFF_FFFF);
                else check("byte", {24'd0, o_byte}, {24'd0, exp_byte_q.pop_front()});
            end
            if (o_rx_done) begin
                check("done_with_valid", {31'd0, o_byte_valid}, 32'd1);
                if (exp_word_q.size() == 0) check("unexpected_rx_done", o_data, 32'hFFFF_FFFF);
                else check("word", o_data, exp_word_q.pop_front());
            end
            if (o_frame_err) begin
                check("frame_err_expected", {31'd0, exp_err > 0}, 32'd1);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    task automatic hold(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip);
        start_cyc = cyc;
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(d[i]);
`ifdef SHIFT2MAT_PARITY_EN
        hold((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        hold(stop_b);
        rx = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_o_byte", {24'd0, o_byte}, 32'd0);
        check("rst_o_data", o_data, 32'd0);
        check("rst_pulses", {29'd0, o_byte_valid, o_rx_done, o_frame_err}, 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        idle(20);

        // Single byte: one valid, no word, latency ~9.5 bits + sync
        exp_byte_q.push_back(8'h55);
        send(8'h55, 1'b1, 1'b0);
        idle(40);
        check("latency_in_range",
              {31'd0, (last_valid_cyc - start_cyc >= 150 + LAT_EXTRA) &&
                      (last_valid_cyc - start_cyc <= 160 + LAT_EXTRA)}, 32'd1);

        // Complete the word back-to-back
        exp_byte_q.push_back(8'h77);
        exp_byte_q.push_back(8'h19);
        exp_byte_q.push_back(8'hA5);
        exp_word_q.push_back(32'hA519_7755);
        send(8'h77, 1'b1, 1'b0);
        send(8'h19, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        idle(40);
        check("word_held", o_data, 32'hA519_7755);

        // Short glitch is rejected
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(30);
        check("glitch_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Bad stop bit: error, then byte index advances by exactly one
        exp_err++;
        send(8'h3C, 1'b0, 1'b0);
        idle(20);
        exp_byte_q.push_back(8'h3C);
        exp_byte_q.push_back(8'h01);
        exp_byte_q.push_back(8'h02);
        exp_byte_q.push_back(8'h03);
        exp_word_q.push_back(32'h0302_013C);
        send(8'h3C, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        idle(40);

        // Reset in mid bit 4 of 0xF0 aborts silently and clears the word
        fork
            send(8'hF0, 1'b1, 1'b0);
            begin
                repeat (5 * CPB + CPB / 2 + 2) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                check("mid_rst_o_data", o_data, 32'd0);
            end
        join
        idle(40);
        exp_byte_q.push_back(8'h0F);
        exp_byte_q.push_back(8'hAA);
        exp_byte_q.push_back(8'hBB);
        exp_byte_q.push_back(8'hCC);
        exp_word_q.push_back(32'hCCBB_AA0F);
        send(8'h0F, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        send(8'hBB, 1'b1, 1'b0);
        send(8'hCC, 1'b1, 1'b0);
        idle(40);

`ifdef SHIFT2MAT_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        exp_err++;
        send(8'h07, 1'b1, 1'b1);
        idle(20);
        exp_byte_q.push_back(8'h07);
        send(8'h07, 1'b1, 1'b0);
        idle(40);
`endif

        check("pending_bytes", 32'(exp_byte_q.size()), 32'd0);
        check("pending_words", 32'(exp_word_q.size()), 32'd0);
        check("pending_errs", 32'(exp_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
